// File: rtl/dmem_cache.sv
// Direct-mapped, write-back, write-allocate byte cache with eight 4-byte lines.
// Misses stall the CPU through busy_wait and move whole 32-bit blocks to and from memory.
module dmem_cache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        read,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  write_data,
  output logic [7:0]  read_data,
  output logic        busy_wait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait
);

  typedef enum logic [1:0] {StIdle, StWriteback, StFill} state_e;

  state_e      state_q;
  logic [7:0]  valid_q;
  logic [7:0]  dirty_q;
  logic [2:0]  tag_q  [8];
  logic [31:0] data_q [8];

  logic [2:0] req_tag;
  logic [2:0] index;
  logic [1:0] offset;
  logic [4:0] byte_lsb;
  logic       req;
  logic       hit;
  logic       idle_hit;

  always_comb begin
    req_tag  = address[7:5];
    index    = address[4:2];
    offset   = address[1:0];
    byte_lsb = {offset, 3'b000};
    req      = read | write;
    hit      = valid_q[index] && (tag_q[index] == req_tag);
    idle_hit = (state_q == StIdle) && hit;
  end

  always_comb begin
    busy_wait     = req & ~idle_hit;
    // A simultaneous read and write is a write, so no load data is returned.
    read_data     = (idle_hit && read && !write) ? data_q[index][byte_lsb +: 8] : 8'h00;
    mem_read      = (state_q == StFill);
    mem_write     = (state_q == StWriteback);
    mem_address   = (state_q == StWriteback) ? {tag_q[index], index} : {req_tag, index};
    mem_writedata = data_q[index];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      valid_q <= 8'h00;
      dirty_q <= 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            if (hit) begin
              if (write) begin
                data_q[index][byte_lsb +: 8] <= write_data;
                dirty_q[index]               <= 1'b1;
              end
            end else if (valid_q[index] && dirty_q[index]) begin
              state_q <= StWriteback;
            end else begin
              state_q <= StFill;
            end
          end
        end
        StWriteback: begin
          if (!mem_busywait) state_q <= StFill;
        end
        StFill: begin
          if (!mem_busywait) begin
            data_q[index]  <= mem_readdata;
            tag_q[index]   <= req_tag;
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_cache.sv
// Self-checking bench for dmem_cache: directed scenarios plus a randomized run
// checked against a flat byte-memory model of what the CPU should observe.
module tb_dmem_cache;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [7:0]  address = 8'h00;
  logic [7:0]  write_data = 8'h00;
  logic [7:0]  read_data;
  logic        busy_wait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int passed = 0;
  int total  = 0;

  dmem_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .read         (read),
    .write        (write),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .busy_wait    (busy_wait),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 CLK = ~CLK;

  // Memory model: a request completes on its lat-th cycle.
  logic [31:0] mem_blk [64];
  int          lat = 5;
  int          mcnt = 0;
  logic        pl_we = 1'b0;
  logic [5:0]  pl_addr = 6'd0;
  logic [31:0] pl_data = 32'd0;

  assign mem_readdata = mem_blk[mem_address];
  assign mem_busywait = (mem_read | mem_write) && (mcnt != lat - 1);

  always @(posedge CLK) begin
    if (pl_we) mem_blk[pl_addr] <= pl_data;
    if (mem_read | mem_write) begin
      if (mem_busywait) mcnt <= mcnt + 1;
      else begin
        mcnt <= 0;
        if (mem_write) mem_blk[mem_address] <= mem_writedata;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Bus monitor: cumulative counts and protocol flags.
  int          cyc = 0;
  int          rd_total = 0;
  int          wr_total = 0;
  int          rd_start = 0;
  int          wr_start = 0;
  logic [5:0]  rd_addr = 6'd0;
  logic [5:0]  wr_addr = 6'd0;
  logic [31:0] wr_data = 32'd0;
  logic        prev_rd = 1'b0;
  logic        prev_wr = 1'b0;
  logic [5:0]  prev_addr = 6'd0;
  logic [31:0] prev_wdata = 32'd0;
  int          overlap_seen = 0;
  int          unstable_seen = 0;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (mem_read && mem_write) overlap_seen = overlap_seen + 1;
    if (mem_read) begin
      if (!prev_rd) rd_start = cyc;
      else if (mem_address !== prev_addr) unstable_seen = unstable_seen + 1;
      rd_total = rd_total + 1;
      rd_addr  = mem_address;
    end
    if (mem_write) begin
      if (!prev_wr) wr_start = cyc;
      else if (mem_address !== prev_addr || mem_writedata !== prev_wdata)
        unstable_seen = unstable_seen + 1;
      wr_total = wr_total + 1;
      wr_addr  = mem_address;
      wr_data  = mem_writedata;
    end
    prev_rd    = mem_read;
    prev_wr    = mem_write;
    prev_addr  = mem_address;
    prev_wdata = mem_writedata;
  end

  task automatic preload(input logic [5:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    @(posedge CLK); #1;
    pl_we   = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    read  = 1'b0;
    write = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  // Issue one CPU request and hold it until busy_wait falls; counts stall cycles.
  task automatic do_req(input logic rd, input logic wr, input logic [7:0] a,
                        input logic [7:0] wd, output int stall, output logic [7:0] rdata);
    read       = rd;
    write      = wr;
    address    = a;
    write_data = wd;
    stall      = 0;
    rdata      = 8'h00;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (!busy_wait) begin
        rdata = read_data;
        break;
      end
      stall++;
    end
    @(posedge CLK); #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    else passed++;
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    do_reset();
    @(negedge CLK);
    total++; if (busy_wait !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_wait); else passed++;
    total++; if (mem_read !== 1'b0) $display("FAIL reset_mem_read: got %b expected 0", mem_read); else passed++;
    total++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write: got %b expected 0", mem_write); else passed++;
    total++; if (read_data !== 8'h00) $display("FAIL reset_read_data: got %h expected 00", read_data); else passed++;
    @(posedge CLK); #1;
    read = 1'b1; address = 8'h33; RESET = 1'b1;
    @(negedge CLK);
    total++; if (busy_wait !== 1'b1) $display("FAIL reset_req_busy: got %b expected 1", busy_wait); else passed++;
    @(posedge CLK); #1;
    read = 1'b0; RESET = 1'b0;
  endtask

  task automatic test_read_miss();
    int s; logic [7:0] d; int r0, w0;
    lat = 5;
    preload(6'h05, 32'h44332211);
    r0 = rd_total; w0 = wr_total;
    do_req(1'b1, 1'b0, 8'h14, 8'h00, s, d);
    total++; if (s != 6) $display("FAIL miss_stall: got %0d expected 6", s); else passed++;
    total++; if (d !== 8'h11) $display("FAIL miss_data: got %h expected 11", d); else passed++;
    total++; if (rd_total - r0 != 5) $display("FAIL miss_rd_cycles: got %0d expected 5", rd_total - r0); else passed++;
    total++; if (rd_addr !== 6'h05) $display("FAIL miss_rd_addr: got %h expected 05", rd_addr); else passed++;
    total++; if (wr_total != w0) $display("FAIL miss_no_write: got %0d expected 0", wr_total - w0); else passed++;
  endtask

  task automatic test_read_hit();
    int s; logic [7:0] d; int r0;
    r0 = rd_total;
    do_req(1'b1, 1'b0, 8'h17, 8'h00, s, d);
    total++; if (s != 0) $display("FAIL hit_stall: got %0d expected 0", s); else passed++;
    total++; if (d !== 8'h44) $display("FAIL hit_data: got %h expected 44", d); else passed++;
    total++; if (rd_total != r0) $display("FAIL hit_no_mem: got %0d expected 0", rd_total - r0); else passed++;
  endtask

  task automatic test_write_hit();
    int s1, s2; logic [7:0] d; int r0, w0;
    r0 = rd_total; w0 = wr_total;
    do_req(1'b0, 1'b1, 8'h15, 8'hAA, s1, d);
    do_req(1'b1, 1'b0, 8'h15, 8'h00, s2, d);
    total++; if (s1 != 0) $display("FAIL whit_stall: got %0d expected 0", s1); else passed++;
    total++; if (s2 != 0) $display("FAIL whit_rd_stall: got %0d expected 0", s2); else passed++;
    total++; if (d !== 8'hAA) $display("FAIL whit_data: got %h expected aa", d); else passed++;
    total++; if (rd_total + wr_total != r0 + w0) $display("FAIL whit_no_mem: got %0d expected 0",
                                                          rd_total + wr_total - r0 - w0); else passed++;
  endtask

  task automatic test_dirty_evict();
    int s; logic [7:0] d;
    lat = 5;
    preload(6'h2D, 32'h0000BEEF);
    do_req(1'b1, 1'b0, 8'hB4, 8'h00, s, d);
    total++; if (s != 11) $display("FAIL evict_stall: got %0d expected 11", s); else passed++;
    total++; if (wr_addr !== 6'h05) $display("FAIL evict_wr_addr: got %h expected 05", wr_addr); else passed++;
    total++; if (wr_data !== 32'h4433AA11) $display("FAIL evict_wr_data: got %h expected 4433aa11", wr_data); else passed++;
    total++; if (rd_addr !== 6'h2D) $display("FAIL evict_rd_addr: got %h expected 2d", rd_addr); else passed++;
    total++; if (!(wr_start < rd_start)) $display("FAIL evict_order: got wr@%0d rd@%0d expected write first", wr_start, rd_start); else passed++;
    total++; if (d !== 8'hEF) $display("FAIL evict_data: got %h expected ef", d); else passed++;
    total++; if (mem_blk[5] !== 32'h4433AA11) $display("FAIL evict_mem: got %h expected 4433aa11", mem_blk[5]); else passed++;
  endtask

  task automatic test_write_miss();
    int s; logic [7:0] d; int w0;
    lat = 5;
    preload(6'h10, 32'h87654321);
    w0 = wr_total;
    do_req(1'b0, 1'b1, 8'h40, 8'h5A, s, d);
    total++; if (s != 6) $display("FAIL wmiss_stall: got %0d expected 6", s); else passed++;
    total++; if (rd_addr !== 6'h10) $display("FAIL wmiss_rd_addr: got %h expected 10", rd_addr); else passed++;
    total++; if (wr_total != w0) $display("FAIL wmiss_no_write: got %0d expected 0", wr_total - w0); else passed++;
    do_req(1'b1, 1'b0, 8'h40, 8'h00, s, d);
    total++; if (d !== 8'h5A) $display("FAIL wmiss_read: got %h expected 5a", d); else passed++;
    do_req(1'b1, 1'b0, 8'h60, 8'h00, s, d);
    total++; if (wr_addr !== 6'h10) $display("FAIL wmiss_evict_addr: got %h expected 10", wr_addr); else passed++;
    total++; if (wr_data !== 32'h8765435A) $display("FAIL wmiss_evict_data: got %h expected 8765435a", wr_data); else passed++;
  endtask

  task automatic test_reset_during_fill();
    int s; logic [7:0] d; int r0;
    lat = 5;
    read = 1'b1; address = 8'h14;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0; read = 1'b0;
    @(negedge CLK);
    total++; if (mem_read !== 1'b0) $display("FAIL rfill_mem_read: got %b expected 0", mem_read); else passed++;
    total++; if (busy_wait !== 1'b0) $display("FAIL rfill_busy: got %b expected 0", busy_wait); else passed++;
    @(posedge CLK); #1;
    r0 = rd_total;
    do_req(1'b1, 1'b0, 8'h14, 8'h00, s, d);
    total++; if (s != 6) $display("FAIL rfill_remiss_stall: got %0d expected 6", s); else passed++;
    total++; if (rd_total - r0 != 5) $display("FAIL rfill_remiss_rd: got %0d expected 5", rd_total - r0); else passed++;
    total++; if (d !== 8'h11) $display("FAIL rfill_data: got %h expected 11", d); else passed++;
  endtask

  // Reference: a flat 256-byte CPU-visible memory plus which block each index holds.
  task automatic test_random();
    logic [7:0]  ref_mem [256];
    logic        m_valid [8];
    logic        m_dirty [8];
    logic [2:0]  m_tag   [8];
    logic [31:0] v;
    logic [31:0] exp_blk;
    logic [7:0]  a, wd, d, ba;
    logic [2:0]  idx, tg;
    logic        rd, wr, hit, evict;
    int          s, r0, w0, exp_s;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      preload(i[5:0], v);
      for (int b = 0; b < 4; b++) ref_mem[i * 4 + b] = v[b * 8 +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 3'd0;
    end
    for (int n = 0; n < 60; n++) begin
      lat = $urandom_range(1, 4);
      a   = {3'($urandom_range(0, 2)), 5'($urandom)};
      wd  = 8'($urandom);
      rd  = ($urandom_range(0, 3) != 0);
      wr  = !rd || ($urandom_range(0, 7) == 0);
      idx = a[4:2];
      tg  = a[7:5];
      hit   = m_valid[idx] && (m_tag[idx] == tg);
      evict = !hit && m_valid[idx] && m_dirty[idx];
      exp_s = hit ? 0 : (evict ? 1 + 2 * lat : 1 + lat);
      for (int b = 0; b < 4; b++) begin
        ba = {m_tag[idx], idx, b[1:0]};
        exp_blk[b * 8 +: 8] = ref_mem[ba];
      end
      r0 = rd_total; w0 = wr_total;
      do_req(rd, wr, a, wd, s, d);
      total++; if (s != exp_s) $display("FAIL rand_stall[%0d]: got %0d expected %0d", n, s, exp_s); else passed++;
      total++; if (wr_total - w0 != (evict ? lat : 0))
        $display("FAIL rand_wr_cycles[%0d]: got %0d expected %0d", n, wr_total - w0, evict ? lat : 0); else passed++;
      total++; if (rd_total - r0 != (hit ? 0 : lat))
        $display("FAIL rand_rd_cycles[%0d]: got %0d expected %0d", n, rd_total - r0, hit ? 0 : lat); else passed++;
      if (evict) begin
        total++; if (wr_data !== exp_blk)
          $display("FAIL rand_wb_data[%0d]: got %h expected %h", n, wr_data, exp_blk); else passed++;
      end
      if (rd && !wr) begin
        total++; if (d !== ref_mem[a])
          $display("FAIL rand_read[%0d]: got %h expected %h", n, d, ref_mem[a]); else passed++;
      end
      if (!hit) begin
        m_valid[idx] = 1'b1; m_tag[idx] = tg; m_dirty[idx] = 1'b0;
      end
      if (wr) begin
        ref_mem[a] = wd; m_dirty[idx] = 1'b1;
      end
    end
    total++; if (overlap_seen != 0) $display("FAIL mem_overlap: got %0d expected 0", overlap_seen); else passed++;
    total++; if (unstable_seen != 0) $display("FAIL mem_unstable: got %0d expected 0", unstable_seen); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_blk[i] = 32'd0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_reset_during_fill();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
